opcode_table: RTL and testbench

OPCODE_TABLE -- requirements
Module: opcode_table

---
 rtl/opcode_table.sv | 208 ++++++++++++++++++++
 tb/tb_opcode_table.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/opcode_table.sv
// opcode_table: small associative key table driven by a command/response
// handshake. Every scanning command walks all DEPTH entries one per cycle,
// so latency is fixed regardless of where (or whether) a key is found.
module opcode_table #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [WIDTH-1:0]         cmd_key,
    output logic                     resp_valid,
    output logic [1:0]               resp_status,
    output logic [$clog2(DEPTH)-1:0] resp_index,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_DELETE = 2'b01;
    localparam logic [1:0] OP_CLEAR  = 2'b10;
    localparam logic [1:0] OP_LOOKUP = 2'b11;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_DUP      = 2'b01;
    localparam logic [1:0] ST_FULL     = 2'b10;
    localparam logic [1:0] ST_NOTFOUND = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        RESP = 2'b10
    } state_t;

    state_t             state_r;
    logic [1:0]         op_r;
    logic [WIDTH-1:0]   key_r;
    logic [IDX_W-1:0]   scan_idx_r;
    logic               match_found_r;
    logic [IDX_W-1:0]   match_idx_r;
    logic               free_found_r;
    logic [IDX_W-1:0]   free_idx_r;
    logic [WIDTH-1:0]   key_mem_r [DEPTH];
    logic [DEPTH-1:0]   valid_r;
    logic [CNT_W-1:0]   count_r;
    logic               full_r;
    logic               resp_valid_r;
    logic [1:0]         resp_status_r;
    logic [IDX_W-1:0]   resp_index_r;

    logic               hit_s;
    logic               free_s;
    logic               last_s;
    logic               match_found_s;
    logic [IDX_W-1:0]   match_idx_s;
    logic               free_found_s;
    logic [IDX_W-1:0]   free_idx_s;

    // Ready is withheld while reset is asserted so no command can slip in.
    assign cmd_ready   = (state_r == IDLE) && !reset;
    assign resp_valid  = resp_valid_r;
    assign resp_status = resp_status_r;
    assign resp_index  = resp_index_r;
    assign count       = count_r;
    assign full        = full_r;

    // Examine the current scan entry and fold it into the lowest-match / lowest-free trackers.
    always_comb begin
        hit_s  = valid_r[scan_idx_r] && (key_mem_r[scan_idx_r] == key_r);
        free_s = !valid_r[scan_idx_r];
        last_s = (scan_idx_r == IDX_W'(DEPTH - 1));
        if (match_found_r) begin
            match_found_s = 1'b1;
            match_idx_s   = match_idx_r;
        end else begin
            match_found_s = hit_s;
            match_idx_s   = scan_idx_r;
        end
        if (free_found_r) begin
            free_found_s = 1'b1;
            free_idx_s   = free_idx_r;
        end else begin
            free_found_s = free_s;
            free_idx_s   = scan_idx_r;
        end
    end

    // Control FSM, table storage and registered response; all table changes land on entry to RESP.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= IDLE;
            op_r          <= 2'b00;
            key_r         <= '0;
            scan_idx_r    <= '0;
            match_found_r <= 1'b0;
            match_idx_r   <= '0;
            free_found_r  <= 1'b0;
            free_idx_r    <= '0;
            valid_r       <= '0;
            count_r       <= '0;
            full_r        <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_status_r <= ST_OK;
            resp_index_r  <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_valid_r <= 1'b0;
                    if (cmd_valid) begin
                        op_r          <= cmd_op;
                        key_r         <= cmd_key;
                        scan_idx_r    <= '0;
                        match_found_r <= 1'b0;
                        free_found_r  <= 1'b0;
                        if (cmd_op == OP_CLEAR) begin
                            // Keys are left in place; dropping the valid bits empties the table.
                            valid_r       <= '0;
                            count_r       <= '0;
                            full_r        <= 1'b0;
                            resp_valid_r  <= 1'b1;
                            resp_status_r <= ST_OK;
                            resp_index_r  <= '0;
                            state_r       <= RESP;
                        end else begin
                            state_r <= SCAN;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end

                SCAN: begin
                    match_found_r <= match_found_s;
                    match_idx_r   <= match_idx_s;
                    free_found_r  <= free_found_s;
                    free_idx_r    <= free_idx_s;
                    if (!last_s) begin
                        scan_idx_r <= scan_idx_r + IDX_W'(1);
                    end else begin
                        scan_idx_r   <= '0;
                        state_r      <= RESP;
                        resp_valid_r <= 1'b1;
                        case (op_r)
                            OP_INSERT: begin
                                if (match_found_s) begin
                                    resp_status_r <= ST_DUP;
                                    resp_index_r  <= match_idx_s;
                                end else if (free_found_s) begin
                                    key_mem_r[free_idx_s] <= key_r;
                                    valid_r[free_idx_s]   <= 1'b1;
                                    count_r               <= count_r + CNT_W'(1);
                                    full_r                <= ((count_r + CNT_W'(1)) == CNT_W'(DEPTH));
                                    resp_status_r         <= ST_OK;
                                    resp_index_r          <= free_idx_s;
                                end else begin
                                    resp_status_r <= ST_FULL;
                                    resp_index_r  <= '0;
                                end
                            end
                            OP_DELETE: begin
                                if (match_found_s) begin
                                    valid_r[match_idx_s] <= 1'b0;
                                    count_r              <= count_r - CNT_W'(1);
                                    full_r               <= 1'b0;
                                    resp_status_r        <= ST_OK;
                                    resp_index_r         <= match_idx_s;
                                end else begin
                                    resp_status_r <= ST_NOTFOUND;
                                    resp_index_r  <= '0;
                                end
                            end
                            OP_LOOKUP: begin
                                if (match_found_s) begin
                                    resp_status_r <= ST_OK;
                                    resp_index_r  <= match_idx_s;
                                end else begin
                                    resp_status_r <= ST_NOTFOUND;
                                    resp_index_r  <= '0;
                                end
                            end
                            default: begin
                                // CLEAR never scans; answer benignly if it ever does.
                                resp_status_r <= ST_OK;
                                resp_index_r  <= '0;
                            end
                        endcase
                    end
                end

                RESP: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end

                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opcode_table.sv
// Bench for opcode_table: directed command sequence with a behavioural
// table model, a per-cycle output compare and literal expectations.
module tb_opcode_table;

    localparam int WIDTH = 11;
    localparam int DEPTH = 8;

    localparam logic [1:0] OP_INS = 2'b00;
    localparam logic [1:0] OP_DEL = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_LKP = 2'b11;

    localparam logic [1:0] S_OK   = 2'b00;
    localparam logic [1:0] S_DUP  = 2'b01;
    localparam logic [1:0] S_FULL = 2'b10;
    localparam logic [1:0] S_NF   = 2'b11;

    logic             clk       = 1'b0;
    logic             reset     = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [1:0]       cmd_op    = 2'b00;
    logic [WIDTH-1:0] cmd_key   = '0;
    logic             cmd_ready;
    logic             resp_valid;
    logic [1:0]       resp_status;
    logic [2:0]       resp_index;
    logic [3:0]       count;
    logic             full;

    opcode_table #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_key     (cmd_key),
        .resp_valid  (resp_valid),
        .resp_status (resp_status),
        .resp_index  (resp_index),
        .count       (count),
        .full        (full)
    );

    always #5 clk = ~clk;

    // Behavioural table model
    logic [WIDTH-1:0] mkey [DEPTH];
    bit               mvalid [DEPTH];
    int               mcount = 0;

    // Expectation state for the per-cycle compare
    int         ncyc       = 0;
    int         acc_cyc    = -1;
    int         exp_resp   = -1;
    int         cnt_before = 0;
    int         cnt_after  = 0;
    logic [1:0] exp_st     = 2'b00;
    logic [1:0] prev_st    = 2'b00;
    int         exp_idx    = 0;
    int         prev_idx   = 0;
    bit         chk_en     = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual %0h required %0h", name, ncyc, act, req);
        end
    endtask

    task automatic compare_cycle();
        bit past;
        bit busy;
        int ec;
        past = (exp_resp >= 0) && (ncyc >= exp_resp);
        busy = (ncyc > acc_cyc) && (ncyc <= exp_resp);
        ec   = past ? cnt_after : cnt_before;
        chk("resp_valid",  32'(resp_valid),  32'(ncyc == exp_resp));
        chk("resp_status", 32'(resp_status), 32'(past ? exp_st : prev_st));
        chk("resp_index",  32'(resp_index),  32'(past ? exp_idx : prev_idx));
        chk("count",       32'(count),       32'(ec));
        chk("full",        32'(full),        32'(ec == DEPTH));
        chk("cmd_ready",   32'(cmd_ready),   32'(!reset && !busy));
    endtask

    // Apply one command to the model: lowest matching and lowest free slots decide the result.
    task automatic model_cmd(input logic [1:0] op, input logic [WIDTH-1:0] key,
                             output logic [1:0] st, output int idx);
        int mi;
        int fi;
        mi = -1;
        fi = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (mi < 0 && mvalid[i] && mkey[i] == key) mi = i;
            if (fi < 0 && !mvalid[i]) fi = i;
        end
        st  = S_OK;
        idx = 0;
        case (op)
            OP_INS: begin
                if (mi >= 0) begin
                    st  = S_DUP;
                    idx = mi;
                end else if (fi >= 0) begin
                    mkey[fi]   = key;
                    mvalid[fi] = 1'b1;
                    mcount++;
                    idx = fi;
                end else begin
                    st = S_FULL;
                end
            end
            OP_DEL: begin
                if (mi >= 0) begin
                    mvalid[mi] = 1'b0;
                    mcount--;
                    idx = mi;
                end else begin
                    st = S_NF;
                end
            end
            OP_LKP: begin
                if (mi >= 0) idx = mi;
                else st = S_NF;
            end
            default: begin
                for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
                mcount = 0;
            end
        endcase
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) mvalid[i] = 1'b0;
        mcount     = 0;
        cnt_before = 0;
        cnt_after  = 0;
        exp_resp   = -1;
        acc_cyc    = -1;
        exp_st     = 2'b00;
        prev_st    = 2'b00;
        exp_idx    = 0;
        prev_idx   = 0;
        @(negedge clk); #1;
        reset = 1'b0;
    endtask

    // Issue one command; lit_* pin the model against hand-computed values.
    task automatic do_cmd(input logic [1:0] op, input logic [WIDTH-1:0] key,
                          input logic [1:0] lit_st, input int lit_idx, input int lit_cnt,
                          input bit noise, input int abort_after);
        int g;
        logic [1:0] st;
        int idx;
        g = 0;
        while (cmd_ready !== 1'b1 && g < 40) begin
            @(negedge clk); #1;
            g++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
        model_cmd(op, key, st, idx);
        chk("model_status", 32'(st), 32'(lit_st));
        chk("model_index",  32'(idx), 32'(lit_idx));
        chk("model_count",  32'(mcount), 32'(lit_cnt));
        prev_st    = exp_st;
        prev_idx   = exp_idx;
        exp_st     = st;
        exp_idx    = idx;
        cnt_before = cnt_after;
        cnt_after  = mcount;
        acc_cyc    = ncyc;
        exp_resp   = ncyc + ((op == OP_CLR) ? 1 : DEPTH + 1);
        cmd_op     = op;
        cmd_key    = key;
        cmd_valid  = 1'b1;
        @(negedge clk); #1;
        if (noise) begin
            // Requests while busy must be ignored.
            cmd_op  = OP_CLR;
            cmd_key = 11'h7AA;
            repeat (3) begin
                @(negedge clk); #1;
            end
        end
        cmd_valid = 1'b0;
        if (abort_after > 0) begin
            repeat (abort_after - 1) begin
                @(negedge clk); #1;
            end
            do_reset();
        end else begin
            while (ncyc <= exp_resp) begin
                @(negedge clk); #1;
            end
        end
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                ncyc++;
                if (chk_en) compare_cycle();
            end
            begin
                #200000;
                $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
                $fatal(1, "watchdog");
            end
        join_none

        repeat (2) @(negedge clk);
        #1;
        chk_en = 1'b1;
        do_reset();

        do_cmd(OP_INS, 11'h5A3, S_OK,  0, 1, 1'b0, 0);
        do_cmd(OP_INS, 11'h5A3, S_DUP, 0, 1, 1'b1, 0);
        do_cmd(OP_LKP, 11'h5A2, S_NF,  0, 1, 1'b0, 0);
        do_cmd(OP_DEL, 11'h5A3, S_OK,  0, 0, 1'b0, 0);

        for (int i = 1; i <= DEPTH; i++) begin
            do_cmd(OP_INS, 11'(i), S_OK, i - 1, i, 1'b0, 0);
        end
        do_cmd(OP_INS, 11'h7FF, S_FULL, 0, 8, 1'b0, 0);
        do_cmd(OP_DEL, 11'h004, S_OK,   3, 7, 1'b0, 0);
        do_cmd(OP_INS, 11'h7FF, S_OK,   3, 8, 1'b0, 0);
        do_cmd(OP_LKP, 11'h7FF, S_OK,   3, 8, 1'b0, 0);

        do_cmd(OP_DEL, 11'h001, S_OK, 0, 7, 1'b0, 0);
        do_cmd(OP_DEL, 11'h002, S_OK, 1, 6, 1'b0, 0);
        do_cmd(OP_DEL, 11'h003, S_OK, 2, 5, 1'b0, 0);
        do_cmd(OP_CLR, 11'h000, S_OK, 0, 0, 1'b0, 0);
        do_cmd(OP_LKP, 11'h005, S_NF, 0, 0, 1'b0, 0);
        do_cmd(OP_LKP, 11'h7FF, S_NF, 0, 0, 1'b0, 0);
        do_cmd(OP_DEL, 11'h005, S_NF, 0, 0, 1'b0, 0);

        do_cmd(OP_INS, 11'h123, S_OK, 0, 1, 1'b0, 0);
        do_cmd(OP_INS, 11'h124, S_OK, 1, 2, 1'b0, 0);
        do_cmd(OP_INS, 11'h555, S_OK, 2, 3, 1'b0, 4);
        repeat (12) begin
            @(negedge clk); #1;
        end
        do_cmd(OP_INS, 11'h555, S_OK, 0, 1, 1'b0, 0);
        do_cmd(OP_LKP, 11'h123, S_NF, 0, 1, 1'b0, 0);

        repeat (3) @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
